output_ram_reader: RTL
======================

# output_ram_reader

Drains result bytes from the 16-entry, 8-bit output-values RAM and presents them one at a time on a valid/ready byte stream. It sits directly downstream of that RAM: it drives the RAM read address and consumes the RAM's `q` port, honouring the RAM's one-cycle registered-address read latency. A `start` pulse selects a base address and a length, and `done` pulses once the last byte has been accepted downstream. Reads wrap modulo the RAM depth.

## Interface
- `DEPTH`, 16 — number of RAM entries; must be a power of two.
- `ADDR_W`, 4 — RAM address width; equals log2(DEPTH).
- `DATA_W`, 8 — RAM word width.

- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — reset, synchronous, active-low.
- `start`  in  1  — begin a transfer; sampled only in IDLE.
- `base`  in  ADDR_W  — first RAM address; sampled with `start`.
- `len`  in  ADDR_W+1  — number of bytes, 0..16; values above DEPTH saturate to DEPTH.
- `ram_addr`  out  ADDR_W  — read address to the RAM.
- `ram_q`  in  DATA_W  — RAM read data, `ram[addr_reg]`.
- `out_data`  out  DATA_W  — stream byte, registered.
- `out_valid`  out  1  — stream byte valid.
- `out_ready`  in  1  — downstream accepts the byte.
- `busy`  out  1  — high in every state except IDLE.
- `done`  out  1  — one-cycle pulse after the final handshake, or after a `len`=0 start.

## Operation
- There are four states: IDLE, ADDR, LOAD and HOLD.
- Internal registers:
  - `idx` (ADDR_W bits), the current address.
  - `rem` (ADDR_W+1 bits), the bytes remaining.
- `ram_addr` = `idx` continuously, so it holds stable across ADDR, LOAD and HOLD.
- **IDLE:**
  - On `start` with saturated `len` ≠ 0: `idx`←`base`, `rem`←saturated `len`, go to ADDR.
  - On `start` with `len` = 0: `done`←1 and stay in IDLE.
  - Without `start`: hold.
- **ADDR:** `ram_addr` is presented for one cycle. The RAM latches it at the end of this cycle. Go to LOAD.
- **LOAD:** `ram_q` is valid. `out_data`←`ram_q`, `out_valid`←1, go to HOLD.
- **HOLD:**
  - `out_data` is held stable while `out_valid`=1 and `out_ready`=0.
  - On `out_valid`&`out_ready`: `out_valid`←0, `idx`←`idx`+1 (mod DEPTH), `rem`←`rem`−1.
  - If `rem` was 1: `done`←1 and go to IDLE. Otherwise go to ADDR.
- `start` in any non-IDLE state is ignored; `base` and `len` are not re-sampled.
- Wrap-around: `base`=14 with `len`=4 reads addresses 14, 15, 0, 1.
- Upstream writers must not write the RAM while `busy`=1. This block never drives write enable.
- **Reset (`rst_n`=0 at an edge), including mid-transfer:**
  - State→IDLE.
  - `idx`, `rem`, `out_data`←0; `out_valid`, `done`←0.
  - A byte in flight is dropped and no `done` is issued.
- **Reset values:** `ram_addr`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0.

## Timing
- `start` is high in cycle 0 (IDLE):
  - ADDR occupies cycle 1, LOAD cycle 2.
  - `out_valid`=1 and `out_data` are first visible in cycle 3.
- With `out_ready` held high, each byte takes 3 cycles: bytes are valid in cycles 3, 6, 9, …
- The handshake completes at the edge where `out_valid`=1 and `out_ready`=1. `out_valid` falls in the next cycle.
- `done` is high for exactly the one cycle after the final handshake edge, with `busy`=0 in that same cycle.
  - Example: `len`=1 with ready high gives the handshake in cycle 3 and `done` in cycle 4.
- For a `len`=0 start, `done` is high in cycle 1 and `busy` stays 0 throughout.
- A new `start` is accepted in the same cycle that `done` is high.
- `out_ready` may toggle arbitrarily. There is no combinational path from `out_ready` to any output.

## Test plan
- **Basic stream:** RAM preloaded with `ram[i]` = 0x10+i; `start`, `base`=0, `len`=4, ready high → `out_data` 0x10, 0x11, 0x12, 0x13 in cycles 3, 6, 9, 12; `done` in cycle 13.
- **Wrap:** `base`=14, `len`=4 → `ram_addr` sequence 14, 15, 0, 1; `out_data` 0x1E, 0x1F, 0x10, 0x11.
- **Backpressure:** `len`=2 with `out_ready` low for 5 cycles after the first valid → `out_data`=0x10 held stable for 6 cycles, no duplicate or skipped bytes, `done` one cycle after the second handshake.
- **Boundaries:**
  - `len`=0 → `done` in cycle 1 and no `out_valid`.
  - `len`=20 → exactly 16 bytes, then `done`.
- **Start while busy:** a second `start` with `base`=8 arrives during a `len`=3 transfer → ignored; only addresses 0..2 are streamed.
- **Mid-operation reset:** `rst_n` low for 1 cycle while in HOLD → `out_valid`, `busy`, `done`=0 and `ram_addr`=0 the next cycle; a subsequent `start` with `base`=5, `len`=1 yields 0x15.

Source files
------------

// File: rtl/output_ram_reader.sv
// Streams bytes out of the output-values RAM on a valid/ready interface.
// Each byte costs one address cycle, one load cycle and at least one hold cycle.
module output_ram_reader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, ADDR, LOAD, HOLD} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] ZERO_L  = '0;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic [ADDR_W:0]   rem, rem_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              valid_nxt;
    logic              done_nxt;

    // Lengths beyond the RAM depth would only re-read wrapped entries, so clamp them.
    function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] l);
        if (l > DEPTH_L)
            return DEPTH_L;
        return l;
    endfunction

    assign ram_addr = idx;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            rem       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            rem       <= rem_nxt;
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        rem_nxt   = rem;
        data_nxt  = out_data;
        valid_nxt = out_valid;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (sat_len(len) == ZERO_L) begin
                        done_nxt = 1'b1;
                    end else begin
                        idx_nxt   = base;
                        rem_nxt   = sat_len(len);
                        state_nxt = ADDR;
                    end
                end
            end
            // RAM registers ram_addr at the end of this cycle.
            ADDR: state_nxt = LOAD;
            LOAD: begin
                data_nxt  = ram_q;
                valid_nxt = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    valid_nxt = 1'b0;
                    idx_nxt   = idx + 1'b1;
                    rem_nxt   = rem - ONE_L;
                    if (rem == ONE_L) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = ADDR;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
